// File: rtl/skinny_msk_pkg.sv
// Shared constants and byte-level helpers for the masked Skinny-128-384 TK3 schedule.
// Cells are 8-bit; each cell holds d Boolean shares packed side by side.
package skinny_msk_pkg;

  localparam int W     = 8;
  localparam int CELLS = 16;

  // new_cell[i] = old_cell[PERM[i]]
  localparam int TK_PERM     [CELLS] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
  localparam int TK_PERM_INV [CELLS] = '{8, 9, 10, 11, 12, 13, 14, 15, 2, 0, 4, 7, 6, 3, 5, 1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    FIN  = 2'd2
  } tk_state_e;

  function automatic logic [W-1:0] lfsr3(input logic [W-1:0] x);
    return {x[0] ^ x[6], x[7:1]};
  endfunction

  function automatic logic [W-1:0] inv_lfsr3(input logic [W-1:0] y);
    return {y[6:0], y[7] ^ y[5]};
  endfunction

endpackage

// File: rtl/msk_inv_tk_round.sv
// One inverse TK3 round, applied share-wise: inverse LFSR3 on cells 8..15,
// then the inverse cell permutation. Purely linear, so shares never mix.
module msk_inv_tk_round
  import skinny_msk_pkg::*;
#(
  parameter int d = 2
) (
  input  logic [CELLS*W*d-1:0] k_i,
  output logic [CELLS*W*d-1:0] k_o
);

  logic [CELLS*W*d-1:0] lf;

  for (genvar c = 0; c < CELLS; c++) begin : g_cell
    for (genvar s = 0; s < d; s++) begin : g_share
      if (c >= 8) begin : g_lfsr
        assign lf[(c*d+s)*W +: W] = inv_lfsr3(k_i[(c*d+s)*W +: W]);
      end else begin : g_pass
        assign lf[(c*d+s)*W +: W] = k_i[(c*d+s)*W +: W];
      end
    end
    assign k_o[c*d*W +: d*W] = lf[TK_PERM_INV[c]*d*W +: d*W];
  end

endmodule

// File: rtl/msk_inv_tweakey_gen.sv
// Masked inverse TK3 tweakey walker: loads a final-round tweakey and steps it
// backward one round per accepted step, feeding round keys in reverse order.
module msk_inv_tweakey_gen
  import skinny_msk_pkg::*;
#(
  parameter int d    = 2,
  parameter int NR_W = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NR_W-1:0]      n_steps_i,
  input  logic                 step_i,
  input  logic [CELLS*W*d-1:0] k_i,
  output logic [CELLS*W*d-1:0] k_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [NR_W-1:0]      rnd_o,
  output tk_state_e            state_o
);

  // Handshake: start_i is a single-cycle command accepted in every state and
  // overrides step_i; step_i is accepted only while busy_o=1, and each accepted
  // step updates k_o and rnd_o on that edge. done_o is a one-cycle pulse.

  tk_state_e state_q, state_d;
  (* keep = "true" *) logic [CELLS*W*d-1:0] k_q;
  logic [CELLS*W*d-1:0] k_d;
  logic [CELLS*W*d-1:0] k_step;
  logic [NR_W-1:0]      rnd_q, rnd_d;

  msk_inv_tk_round #(.d(d)) u_round (
    .k_i (k_q),
    .k_o (k_step)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rnd_d   = rnd_q;
    if (start_i) begin
      k_d     = k_i;
      rnd_d   = n_steps_i;
      state_d = (n_steps_i == '0) ? FIN : WALK;
    end else begin
      case (state_q)
        WALK: begin
          // rnd_q is never 0 in WALK; the guard keeps the counter from wrapping.
          if (step_i && rnd_q != '0) begin
            k_d   = k_step;
            rnd_d = rnd_q - NR_W'(1);
            if (rnd_q == NR_W'(1)) state_d = FIN;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  assign k_o     = k_q;
  assign rnd_o   = rnd_q;
  assign busy_o  = (state_q == WALK);
  assign done_o  = (state_q == FIN);
  assign state_o = state_q;

endmodule

// File: tb/tb_msk_inv_tweakey_gen.sv
// Bench for msk_inv_tweakey_gen (d=2): impulse table, forward/backward round trip,
// gapped steps, abort by start and by reset, and the zero-step load.
module tb_msk_inv_tweakey_gen;
  import skinny_msk_pkg::*;

  localparam int D    = 2;
  localparam int NR_W = 6;
  localparam int KW   = 128 * D;

  typedef logic [7:0] cells_t [16];
  typedef struct {
    int         in_cell;
    int         sh;
    logic [7:0] in_val;
    int         exp_cell;
    logic [7:0] exp_val;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst, start, step;
  logic [NR_W-1:0] n_steps;
  logic [KW-1:0]   k_in, k_out;
  logic            busy, done;
  logic [NR_W-1:0] rnd;
  tk_state_e       state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msk_inv_tweakey_gen #(.d(D), .NR_W(NR_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .n_steps_i (n_steps),
    .step_i    (step),
    .k_i       (k_in),
    .k_o       (k_out),
    .busy_o    (busy),
    .done_o    (done),
    .rnd_o     (rnd),
    .state_o   (state)
  );

  // ---------------- reference model ----------------
  localparam int PT [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] m_lfsr(logic [7:0] x);
    return {x[0] ^ x[6], x[7:1]};
  endfunction

  function automatic cells_t m_fwd(cells_t o);
    cells_t n;
    for (int i = 0; i < 16; i++) n[i] = o[PT[i]];
    for (int i = 8; i < 16; i++) n[i] = m_lfsr(n[i]);
    return n;
  endfunction

  // Inverse derived from the forward rules: undo LFSR by table, then scatter back.
  function automatic cells_t m_inv(cells_t n);
    cells_t t, o;
    for (int i = 0; i < 16; i++) t[i] = (i >= 8) ? inv_tab[n[i]] : n[i];
    for (int i = 0; i < 16; i++) o[PT[i]] = t[i];
    return o;
  endfunction

  function automatic logic [KW-1:0] pack(cells_t a, cells_t b);
    logic [KW-1:0] r;
    r = '0;
    for (int c = 0; c < 16; c++) begin
      r[(c*2)*8 +: 8]   = a[c];
      r[(c*2+1)*8 +: 8] = b[c];
    end
    return r;
  endfunction

  function automatic cells_t unmask(logic [KW-1:0] k);
    cells_t r;
    for (int c = 0; c < 16; c++) r[c] = k[(c*2)*8 +: 8] ^ k[(c*2+1)*8 +: 8];
    return r;
  endfunction

  function automatic cells_t rand_cells();
    cells_t r;
    for (int c = 0; c < 16; c++) r[c] = 8'($urandom);
    return r;
  endfunction

  function automatic cells_t zero_cells();
    cells_t r;
    for (int c = 0; c < 16; c++) r[c] = 8'h00;
    return r;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [KW-1:0] k, input int n);
    k_in    = k;
    n_steps = NR_W'(n);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic chk_k(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t   vec [8];
  cells_t a, b, ea, eb, a0, b0, u;
  int     rem, early;

  initial begin
    for (int v = 0; v < 256; v++) inv_tab[m_lfsr(8'(v))] = 8'(v);

    vec[0] = '{8,  0, 8'h01, 0,  8'h02};
    vec[1] = '{8,  1, 8'h80, 0,  8'h01};
    vec[2] = '{9,  0, 8'h20, 1,  8'h41};
    vec[3] = '{0,  1, 8'h5A, 9,  8'h5A};
    vec[4] = '{15, 0, 8'hFF, 7,  8'hFE};
    vec[5] = '{3,  0, 8'h11, 13, 8'h11};
    vec[6] = '{12, 1, 8'h03, 4,  8'h06};
    vec[7] = '{1,  0, 8'hC3, 15, 8'hC3};

    rst = 1'b1; start = 1'b0; step = 1'b0; n_steps = '0; k_in = '0;
    tick();
    tick();
    chk_k("rst_key", k_out, '0);
    chk_v("rst_busy", 32'(busy), 0);
    chk_v("rst_done", 32'(done), 0);
    chk_v("rst_rnd", 32'(rnd), 0);
    chk_v("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    tick();

    // Single-cell impulses through one inverse step.
    for (int t = 0; t < 8; t++) begin
      a = zero_cells(); b = zero_cells(); ea = zero_cells(); eb = zero_cells();
      if (vec[t].sh == 0) begin
        a[vec[t].in_cell] = vec[t].in_val;  ea[vec[t].exp_cell] = vec[t].exp_val;
      end else begin
        b[vec[t].in_cell] = vec[t].in_val;  eb[vec[t].exp_cell] = vec[t].exp_val;
      end
      load(pack(a, b), 1);
      chk_v("vec_busy", 32'(busy), 1);
      do_step();
      chk_k("vec_key", k_out, pack(ea, eb));
      chk_v("vec_done", 32'(done), 1);
    end

    // Forward 56 rounds in the model, then walk back in the DUT.
    a0 = rand_cells(); b0 = rand_cells();
    a = a0; b = b0;
    for (int r = 0; r < 56; r++) begin
      a = m_fwd(a); b = m_fwd(b);
    end
    load(pack(a, b), 56);
    chk_v("rt_busy", 32'(busy), 1);
    chk_v("rt_rnd", 32'(rnd), 56);
    early = 0;
    for (int i = 0; i < 56; i++) begin
      do_step();
      if (i < 55 && done) early++;
    end
    chk_v("rt_early_done", 32'(early), 0);
    chk_v("rt_done", 32'(done), 1);
    chk_v("rt_rnd0", 32'(rnd), 0);
    chk_v("rt_busy0", 32'(busy), 0);
    u = unmask(k_out);
    for (int c = 0; c < 16; c++) ea[c] = a0[c] ^ b0[c];
    chk_k("rt_unmasked", pack(u, zero_cells()), pack(ea, zero_cells()));
    chk_k("rt_shares", k_out, pack(a0, b0));
    tick();
    chk_v("rt_done_pulse", 32'(done), 0);
    chk_v("rt_idle", 32'(state), 32'(IDLE));
    chk_k("rt_hold", k_out, pack(a0, b0));

    // Steps with random gaps over a 5-round walk.
    a = rand_cells(); b = rand_cells();
    load(pack(a, b), 5);
    ea = a; eb = b; rem = 5;
    for (int cyc = 0; cyc < 60 && rem > 0; cyc++) begin
      step = ($urandom_range(0, 2) == 0);
      tick();
      if (step) begin
        ea = m_inv(ea); eb = m_inv(eb); rem--;
      end
      chk_k("gap_key", k_out, pack(ea, eb));
      chk_v("gap_rnd", 32'(rnd), 32'(rem));
    end
    step = 1'b0;
    chk_v("gap_timeout", 32'(rem), 0);
    for (int i = 0; i < 5; i++) begin
      a = m_inv(a); b = m_inv(b);
    end
    chk_k("gap_final", k_out, pack(a, b));
    chk_v("gap_done", 32'(done), 1);

    // Start in WALK aborts the walk and reloads.
    load(pack(rand_cells(), rand_cells()), 20);
    for (int i = 0; i < 10; i++) do_step();
    chk_v("abort_rnd10", 32'(rnd), 10);
    a = rand_cells(); b = rand_cells();
    load(pack(a, b), 7);
    chk_v("abort_rnd", 32'(rnd), 7);
    chk_k("abort_key", k_out, pack(a, b));
    chk_v("abort_done", 32'(done), 0);
    chk_v("abort_busy", 32'(busy), 1);
    early = 0;
    for (int i = 0; i < 7; i++) begin
      do_step();
      if (i < 6 && done) early++;
      a = m_inv(a); b = m_inv(b);
    end
    chk_v("abort_early_done", 32'(early), 0);
    chk_v("abort_fin_done", 32'(done), 1);
    chk_k("abort_fin_key", k_out, pack(a, b));

    // Reset in WALK with rnd=3.
    load(pack(rand_cells(), rand_cells()), 5);
    do_step();
    do_step();
    chk_v("rstw_rnd3", 32'(rnd), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_k("rstw_key", k_out, '0);
    chk_v("rstw_busy", 32'(busy), 0);
    chk_v("rstw_rnd", 32'(rnd), 0);
    chk_v("rstw_state", 32'(state), 32'(IDLE));
    chk_v("rstw_done", 32'(done), 0);
    step = 1'b1;
    tick(); tick(); tick();
    step = 1'b0;
    chk_k("rstw_step_key", k_out, '0);
    chk_v("rstw_step_rnd", 32'(rnd), 0);
    chk_v("rstw_step_state", 32'(state), 32'(IDLE));

    // Zero-step load: straight to FIN, steps ignored there.
    a = rand_cells(); b = rand_cells();
    load(pack(a, b), 0);
    chk_v("zero_busy", 32'(busy), 0);
    chk_v("zero_done", 32'(done), 1);
    chk_v("zero_state", 32'(state), 32'(FIN));
    chk_k("zero_key", k_out, pack(a, b));
    do_step();
    chk_v("zero_done_pulse", 32'(done), 0);
    chk_v("zero_idle", 32'(state), 32'(IDLE));
    chk_v("zero_busy2", 32'(busy), 0);
    chk_k("zero_hold", k_out, pack(a, b));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msk_inv_tweakey_gen.md
Name: msk_inv_tweakey_gen

Overview:
Masked (d-share) inverse TK3 tweakey schedule for the Skinny-128-384 DPA core. It loads a final-round tweakey and walks it backward one round per step, undoing the permutation and LFSR3 update of the forward generator. It feeds round keys in reverse order to the decryption/tag-verify datapath. All operations are share-wise linear, so no fresh randomness is needed and shares never combine.

Parameters:
d, 2, number of Boolean shares
NR_W, 6, width of round counter (supports up to 63 inverse steps)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  load K_in and n_steps; begins a new walk
n_steps  in  NR_W  number of inverse rounds to apply after load
step  in  1  request one inverse round
K_in  in  128*d  masked final tweakey, cell layout identical to the forward generator
K_out  out  128*d  current masked tweakey (registered)
busy  out  1  walk loaded and not finished
done  out  1  one-cycle pulse when the remaining count reaches 0
rnd  out  NR_W  remaining inverse steps

Behaviour:
- Cell i occupies bits [(i+1)*8*d-1 : i*8*d]. Each cell holds d shares of 8 bits, as in the forward generator.
- Inverse step: for cells 8..15, apply inverse LFSR3 per share: y -> {y6,y5,y4,y3,y2,y1,y0,y7^y5}. Cells 0..7 pass through. Then apply inverse tweak permutation P^-1 = [8,9,10,11,12,13,14,15,2,0,4,7,6,3,5,1] at cell level. The step is the exact inverse of the forward step (permutation, then LFSR3 on cells 8..15).
- Reset (rst=1 at clk edge): FSM=IDLE, K_out=0, rnd=0, busy=0, done=0. Reset mid-walk aborts immediately and leaves no partial state.
- States: IDLE, WALK, FIN.
- IDLE + start: on the next edge, K_out<=K_in and rnd<=n_steps.
  - If n_steps=0, go to FIN and pulse done next cycle.
  - Otherwise go to WALK with busy=1.
- WALK + step: on the edge, K_out<=inv_step(K_out) and rnd<=rnd-1.
  - If rnd was 1, go to FIN.
  - step=0 holds all registers (no bubbles inserted, key stable).
- FIN: done=1 for exactly one cycle, busy=0, K_out held. Then go to IDLE with K_out still held until the next start.
- start in WALK or FIN takes priority over step: reload, drop the old walk, no done pulse for the aborted walk.
- step in IDLE or FIN is ignored.
- Latency: K_out updates 1 cycle after the start or step edge. Whole walk = n_steps accepted steps + 1 cycle.
- rnd never underflows. It is decremented only in WALK with rnd>=1.
- Output registers carry keep attributes so shares stay separate through synthesis.

Decomposition:
- Shared package (skinny_msk_pkg):
  - W=8, cell count 16
  - forward and inverse TK permutation index constants
  - LFSR3 and inverse-LFSR3 byte functions
- One sub-module: msk_inv_tk_round (combinational, parameter d). Applies inverse LFSR3 to cells 8..15, then P^-1. It is instantiated once; the FSM and counter wrap it.

Test Plan:
- d=2, run the forward generator 56 rounds from random shares K0 to KF. Load KF with n_steps=56 and issue 56 steps. Then K_out shares XOR to the unmasked K0; done pulses at cycle 57; rnd=0.
- Load with n_steps=0 -> busy stays 0, done pulses on the cycle after the load, K_out=K_in.
- Single cell test: cell 8 share0=0x01, all else 0, one step -> inverse-LFSR3(0x01)=0x02 lands at cell index P^-1 position of 8 (cell 0), share1 stays 0.
- Issue steps with gaps (step=1,0,0,1,…) over 5 rounds -> K_out changes only on step cycles; final value equals 5 back-to-back steps.
- Assert start in WALK with rnd=10 -> reload, rnd=new n_steps, no done for the aborted walk.
- Assert rst in WALK with rnd=3 -> next cycle K_out=0, busy=0, rnd=0, state IDLE; later steps are ignored.
